arbitro_rr: RTL

Round-robin arbiter that drains four upstream FIFOs into the 4:1 `mux` datapath stage. It watches the FIFOs' empty flags and the downstream pause request, issues one-hot pops, and drives `selector_mux` so the mux forwards the popped word. A registered `valido` strobe qualifies `salida_mux`. Each grant lasts for a bounded burst.

---
 rtl/arbitro_pkg.sv | 17 +
 rtl/prioridad_rr.sv | 29 ++
 rtl/arbitro_rr.sv | 103 ++++++++++
 3 files changed

// File: rtl/arbitro_pkg.sv
// Shared types and constants for the four-queue round-robin arbiter.
package arbitro_pkg;

    localparam int NUM_COLAS = 4;
    localparam int SEL_BITS  = $clog2(NUM_COLAS);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RAFAGA = 1'b1
    } estado_t;

    // Next queue index; the index width makes it wrap modulo NUM_COLAS.
    function automatic logic [SEL_BITS-1:0] siguiente(input logic [SEL_BITS-1:0] idx);
        return idx + SEL_BITS'(1);
    endfunction

endpackage

// File: rtl/prioridad_rr.sv
// Wrap-around search: first non-empty queue starting at puntero.
module prioridad_rr
    import arbitro_pkg::*;
(
    input  logic [NUM_COLAS-1:0] vacio,
    input  logic [SEL_BITS-1:0]  puntero,
    output logic                 hay,
    output logic [SEL_BITS-1:0]  indice
);

    // Priority scan from puntero upwards; the first hit wins.
    always_comb begin : busqueda
        logic [SEL_BITS-1:0] cand;
        cand   = '0;
        hay    = 1'b0;
        indice = puntero;
        for (int k = 0; k < NUM_COLAS; k++) begin
            cand = puntero + k[SEL_BITS-1:0];
            if (!hay && !vacio[cand]) begin
                hay    = 1'b1;
                indice = cand;
            end else begin
                hay    = hay;
                indice = indice;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr.sv
// Round-robin burst arbiter draining four FIFOs into the 4:1 mux stage.
// pop is combinational; selector_mux and valido line up with the FIFO read data.
module arbitro_rr
    import arbitro_pkg::*;
#(
    parameter int DATA_BITS  = 4,
    parameter int RAFAGA_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enb,
    input  logic [NUM_COLAS-1:0] vacio,
    input  logic                 pausa,
    output logic [NUM_COLAS-1:0] pop,
    output logic [SEL_BITS-1:0]  selector_mux,
    output logic                 valido
);

    if (RAFAGA_MAX < 1 || RAFAGA_MAX > 15 || DATA_BITS < 1) begin : g_param_invalido
        $error("arbitro_rr: parameter out of range");
    end

    localparam logic [3:0] CUENTA_ULT = 4'(RAFAGA_MAX - 1);

    estado_t               estado_q;
    logic [SEL_BITS-1:0]   puntero_q;
    logic [SEL_BITS-1:0]   actual_q;
    logic [3:0]            cuenta_q;
    logic                  hay_s;
    logic [SEL_BITS-1:0]   indice_s;
    logic [NUM_COLAS-1:0]  pop_s;

    prioridad_rr u_prioridad (
        .vacio   (vacio),
        .puntero (puntero_q),
        .hay     (hay_s),
        .indice  (indice_s)
    );

    // Read strobe: only the granted queue, only when it can deliver a word.
    always_comb begin
        pop_s = '0;
        if (!reset && estado_q == RAFAGA && enb && !pausa && !vacio[actual_q]) begin
            pop_s[actual_q] = 1'b1;
        end else begin
            pop_s = '0;
        end
    end

    assign pop = pop_s;

    // Grant/burst FSM plus the registered mux-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= IDLE;
            puntero_q    <= '0;
            actual_q     <= '0;
            cuenta_q     <= 4'd0;
            selector_mux <= '0;
            valido       <= 1'b0;
        end else begin
            valido <= |pop_s;
            if (|pop_s) begin
                selector_mux <= actual_q;
            end else begin
                selector_mux <= selector_mux;
            end
            case (estado_q)
                IDLE: begin
                    if (enb && !pausa && hay_s) begin
                        actual_q <= indice_s;
                        cuenta_q <= 4'd0;
                        estado_q <= RAFAGA;
                    end else begin
                        estado_q <= IDLE;
                    end
                end
                RAFAGA: begin
                    // A queue that empties under pausa is not yet considered drained.
                    if (!enb || (!pausa && vacio[actual_q])) begin
                        estado_q  <= IDLE;
                        puntero_q <= siguiente(actual_q);
                        cuenta_q  <= 4'd0;
                    end else if (|pop_s) begin
                        if (cuenta_q == CUENTA_ULT) begin
                            estado_q  <= IDLE;
                            puntero_q <= siguiente(actual_q);
                            cuenta_q  <= 4'd0;
                        end else begin
                            cuenta_q <= cuenta_q + 4'd1;
                        end
                    end else begin
                        cuenta_q <= cuenta_q;
                    end
                end
                default: begin
                    estado_q <= IDLE;
                end
            endcase
        end
    end

endmodule
